// File: rtl/hdc_msg_packer.sv
// Streaming front end for the HDC classifier: packs a byte stream into the wide msg bus,
// holds it for a settle window, samples the classifier result and reports it with running counts.
module hdc_msg_packer #(
    parameter int unsigned MESSAGE_LENGTH = 200,
    parameter int unsigned CHAR_LENGTH    = 8,
    parameter int unsigned SETTLE_CYCLES  = 100
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [CHAR_LENGTH-1:0]              s_data,
    input  logic                                s_last,
    input  logic [1:0]                          s_label,
    output logic [CHAR_LENGTH*MESSAGE_LENGTH-1:0] msg,
    output logic [7:0]                          length,
    output logic [1:0]                          label,
    input  logic [1:0]                          cls_result,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [1:0]                          out_result,
    output logic [1:0]                          out_expected,
    output logic                                out_match,
    output logic                                out_inconclusive,
    output logic                                out_truncated,
    output logic [15:0]                         test_count,
    output logic [15:0]                         correct_count
);

    localparam int unsigned   CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [7:0]    MAX_LEN  = 8'(MESSAGE_LENGTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [15:0]   CNT_SAT  = 16'hFFFF;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SETTLE = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] settle_cnt;
    logic             truncated;
    logic             accept;
    logic             inconclusive_c;
    logic             match_c;

    assign accept         = s_valid && s_ready;
    assign inconclusive_c = (cls_result == 2'b11);
    assign match_c        = (cls_result == label) && !inconclusive_c;

    // Fill / settle / report sequencer with all outputs registered
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= FILL;
            settle_cnt       <= '0;
            truncated        <= 1'b0;
            s_ready          <= 1'b0;
            msg              <= '0;
            length           <= '0;
            label            <= '0;
            out_valid        <= 1'b0;
            out_result       <= '0;
            out_expected     <= '0;
            out_match        <= 1'b0;
            out_inconclusive <= 1'b0;
            out_truncated    <= 1'b0;
            test_count       <= '0;
            correct_count    <= '0;
        end else begin
            case (state)
                FILL: begin
                    s_ready <= 1'b1;
                    if (accept) begin
                        // First character lands in the MSBs; beats past capacity are dropped
                        if (length < MAX_LEN) begin
                            for (int unsigned i = 0; i < MESSAGE_LENGTH; i++) begin
                                if (length == 8'(i)) begin
                                    msg[CHAR_LENGTH*(MESSAGE_LENGTH-i)-1 -: CHAR_LENGTH] <= s_data;
                                end
                            end
                            length <= length + 8'd1;
                        end else begin
                            truncated <= 1'b1;
                        end
                        if (s_last) begin
                            label      <= s_label;
                            settle_cnt <= '0;
                            s_ready    <= 1'b0;
                            state      <= SETTLE;
                        end
                    end
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt + CNT_W'(1);
                    if (settle_cnt == CNT_LAST) begin
                        out_result       <= cls_result;
                        out_expected     <= label;
                        out_inconclusive <= inconclusive_c;
                        out_match        <= match_c;
                        out_truncated    <= truncated;
                        out_valid        <= 1'b1;
                        if (test_count != CNT_SAT) begin
                            test_count <= test_count + 16'd1;
                        end
                        if (match_c && (correct_count != CNT_SAT)) begin
                            correct_count <= correct_count + 16'd1;
                        end
                        state <= REPORT;
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        msg       <= '0;
                        length    <= '0;
                        label     <= '0;
                        truncated <= 1'b0;
                        s_ready   <= 1'b1;
                        state     <= FILL;
                    end
                end
                default: begin
                    state <= FILL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hdc_msg_packer.sv
// Scoreboard bench for hdc_msg_packer: randomized messages, reference results queued at
// issue time and checked by an independent monitor when reports appear.
module tb_hdc_msg_packer;

    localparam int unsigned ML    = 200;
    localparam int unsigned CL    = 8;
    localparam int unsigned SC    = 8;
    localparam int unsigned MSG_W = ML * CL;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [CL-1:0]    s_data;
    logic             s_last;
    logic [1:0]       s_label;
    logic [MSG_W-1:0] msg;
    logic [7:0]       length;
    logic [1:0]       label;
    logic [1:0]       cls_result;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       out_result;
    logic [1:0]       out_expected;
    logic             out_match;
    logic             out_inconclusive;
    logic             out_truncated;
    logic [15:0]      test_count;
    logic [15:0]      correct_count;

    hdc_msg_packer #(
        .MESSAGE_LENGTH (ML),
        .CHAR_LENGTH    (CL),
        .SETTLE_CYCLES  (SC)
    ) dut (
        .clk              (clk),
        .reset            (rst_n),
        .s_valid          (s_valid),
        .s_ready          (s_ready),
        .s_data           (s_data),
        .s_last           (s_last),
        .s_label          (s_label),
        .msg              (msg),
        .length           (length),
        .label            (label),
        .cls_result       (cls_result),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_result       (out_result),
        .out_expected     (out_expected),
        .out_match        (out_match),
        .out_inconclusive (out_inconclusive),
        .out_truncated    (out_truncated),
        .test_count       (test_count),
        .correct_count    (correct_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [MSG_W-1:0] msg;
        logic [7:0]       len;
        logic [1:0]       res;
        logic [1:0]       expv;
        logic             match;
        logic             inc;
        logic             trunc;
        logic [15:0]      tc;
        logic [15:0]      cc;
        int unsigned      due;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        cur;
    logic [7:0]  chars[$];
    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int unsigned m_tests = 0;
    int unsigned m_correct = 0;
    int          rdy_mode = 2;
    bit          seen = 0;
    bit          hs_prev = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready policy: 0 random, 1 stalled, 2 always ready
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0)      out_ready = 1'($urandom_range(0, 1));
        else if (rdy_mode == 1) out_ready = 1'b0;
        else                    out_ready = 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_msg(input logic [MSG_W-1:0] act, input logic [MSG_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL msg: got hi %h lo %h, expected hi %h lo %h",
                     act[MSG_W-1 -: 64], act[63:0], exp[MSG_W-1 -: 64], exp[63:0]);
        end
    endtask

    // Monitor: pop on each new report, then hold the report fields to it until the handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            seen    = 0;
            hs_prev = 0;
        end else begin
            if (hs_prev) begin
                chk("post_hs_s_ready", 64'(s_ready), 64'd1);
                chk("post_hs_out_valid", 64'(out_valid), 64'd0);
                chk("post_hs_msg_clear", 64'(|msg), 64'd0);
                chk("post_hs_length", 64'(length), 64'd0);
                hs_prev = 0;
            end
            if (out_valid) begin
                if (!seen) begin
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_report: got out_valid=1, expected no report (cycle %0d)", cyc);
                    end else begin
                        cur = exp_q.pop_front();
                        chk("report_latency", 64'(cyc), 64'(cur.due));
                        chk_msg(msg, cur.msg);
                        chk("length", 64'(length), 64'(cur.len));
                    end
                    seen = 1;
                end
                chk("out_fields",
                    64'({out_result, out_expected, out_match, out_inconclusive, out_truncated}),
                    64'({cur.res, cur.expv, cur.match, cur.inc, cur.trunc}));
                chk("counts", 64'({test_count, correct_count}), 64'({cur.tc, cur.cc}));
                chk("report_s_ready", 64'(s_ready), 64'd0);
                if (out_ready) begin
                    hs_prev = 1;
                    seen    = 0;
                end
            end
        end
    end

    // Drives the bytes in chars[] as one message; queues the reference report
    task automatic send_msg(input logic [1:0] lbl, input logic [1:0] res);
        int   n = chars.size();
        exp_t e;
        int   guard = 0;
        int   k = 0;
        cls_result = res;
        e.msg = '0;
        for (int i = 0; i < n && i < int'(ML); i++)
            e.msg = e.msg | (MSG_W'(chars[i]) << (CL * (ML - 1 - i)));
        e.len   = 8'((n > int'(ML)) ? ML : n);
        e.trunc = (n > int'(ML));
        e.res   = res;
        e.expv  = lbl;
        e.inc   = (res == 2'b11);
        e.match = (res == lbl) && (res != 2'b11);
        if (m_tests < 65535) m_tests++;
        if (e.match && m_correct < 65535) m_correct++;
        e.tc = 16'(m_tests);
        e.cc = 16'(m_correct);
        while (k < n) begin
            guard++;
            if (guard > 5000) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: got %0d beats accepted, expected %0d", k, n);
                s_valid = 1'b0;
                return;
            end
            if ($urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                @(posedge clk);
                #1;
            end else begin
                s_valid = 1'b1;
                s_data  = chars[k];
                s_last  = (k == n - 1);
                s_label = (k == n - 1) ? lbl : 2'($urandom_range(0, 3));
                if (s_ready) begin
                    @(posedge clk);
                    #1;
                    if (k == n - 1) begin
                        e.due = cyc + SC;
                        exp_q.push_back(e);
                    end
                    k++;
                end else begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0 && s_ready && !out_valid) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL idle_timeout: got %0d reports pending, expected 0", exp_q.size());
    endtask

    task automatic rand_chars(input int n);
        chars.delete();
        for (int i = 0; i < n; i++) chars.push_back(8'($urandom_range(0, 255)));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; s_label = '0;
        cls_result = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs",
            64'({s_ready, out_valid, |msg, length, label, out_result, out_expected,
                 out_match, out_inconclusive, out_truncated, test_count, correct_count}), 64'd0);
        rst_n = 1'b1;
        chk("s_ready_before_edge", 64'(s_ready), 64'd0);
        @(posedge clk);
        #1;
        chk("s_ready_after_edge", 64'(s_ready), 64'd1);

        // Basic ham
        chars.delete();
        chars.push_back(8'h48); chars.push_back(8'h69); chars.push_back(8'h21);
        send_msg(2'b00, 2'b00);
        wait_idle(100);
        // Mismatch, then inconclusive
        rand_chars(4);
        send_msg(2'b01, 2'b00);
        wait_idle(100);
        rand_chars(5);
        send_msg(2'b10, 2'b11);
        wait_idle(100);

        // Randomized messages with random report backpressure
        rdy_mode = 0;
        for (int m = 0; m < 12; m++) begin
            rand_chars($urandom_range(1, 12));
            send_msg(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            wait_idle(200);
        end
        rdy_mode = 2;

        // Overflow at the capacity boundary and beyond
        rand_chars(ML);
        send_msg(2'b00, 2'b00);
        wait_idle(100);
        rand_chars(ML + 5);
        send_msg(2'b01, 2'b01);
        wait_idle(100);
        rand_chars(2);
        send_msg(2'b01, 2'b01);
        wait_idle(100);

        // Long report stall with cls_result and s_valid activity
        rdy_mode = 1;
        rand_chars(3);
        send_msg(2'b10, 2'b10);
        for (int i = 0; i < 200 && !out_valid; i++) begin
            @(posedge clk);
            #1;
        end
        chk("stall_reached_report", 64'(out_valid), 64'd1);
        for (int i = 0; i < 50; i++) begin
            cls_result = 2'($urandom_range(0, 3));
            s_valid    = 1'b1;
            s_data     = 8'($urandom_range(0, 255));
            s_last     = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        s_valid  = 1'b0;
        s_last   = 1'b0;
        rdy_mode = 2;
        wait_idle(100);

        // Reset in the middle of the settle window
        rand_chars(2);
        send_msg(2'b00, 2'b00);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        m_tests   = 0;
        m_correct = 0;
        #1;
        chk("midreset_outputs",
            64'({s_ready, out_valid, |msg, length, label, out_result, out_expected,
                 out_match, out_inconclusive, out_truncated, test_count, correct_count}), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chars.delete();
        chars.push_back(8'h5A);
        send_msg(2'b00, 2'b00);
        wait_idle(100);

        // Saturation of both counters
        force dut.test_count    = 16'hFFFE;
        force dut.correct_count = 16'hFFFE;
        @(posedge clk);
        #1;
        release dut.test_count;
        release dut.correct_count;
        m_tests   = 65534;
        m_correct = 65534;
        @(posedge clk);
        #1;
        chk("counts_preload", 64'({test_count, correct_count}), 64'h0000_0000_FFFE_FFFE);
        for (int m = 0; m < 3; m++) begin
            rand_chars(2);
            send_msg(2'b01, 2'b01);
            wait_idle(100);
        end
        chk("counts_saturated", 64'({test_count, correct_count}), 64'h0000_0000_FFFF_FFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
